climate_controller: RTL

Sequential thermostat controller for the two-sensor climate panel. Filters the raw sensor pair, then drives heater, cooler and alarm through a Moore state machine with minimum on-time protection and a latched fault. Sits between the SWI sensor inputs and the LED/SEG actuator outputs in `top`, replacing the purely combinational decode.

---
 rtl/climate_pkg.sv | 20 ++
 rtl/sensor_debounce.sv | 47 ++++
 rtl/climate_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/climate_pkg.sv
// climate_pkg: shared state encoding and sensor code constants for the
// climate controller and its sensor debouncer.
package climate_pkg;

  // Controller states; the numeric value is shown directly on the LED display.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAT  = 3'd1,
    ST_COOL  = 3'd2,
    ST_DEADT = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // Raw sensor codes: bit1 = above minimum temperature, bit0 = above maximum.
  localparam logic [1:0] SENS_COLD  = 2'b00;
  localparam logic [1:0] SENS_FAULT = 2'b01; // physically inconsistent pair
  localparam logic [1:0] SENS_OK    = 2'b10;
  localparam logic [1:0] SENS_HOT   = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: accepts a raw 2-bit sensor code into s_stable only after it
// has been sampled unchanged on DEBOUNCE consecutive rising edges. Any change
// restarts the run, so pulses shorter than DEBOUNCE cycles never get through.
module sensor_debounce
  import climate_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk_2,
  input  logic       rst_n,
  input  logic [1:0] raw,
  output logic [1:0] s_stable
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE);

  logic [1:0]    cand;
  logic [CW-1:0] run_cnt;   // consecutive samples equal to cand, saturating
  logic [CW-1:0] run_next;  // run length including the sample taken this edge

  // Length of the current run of identical samples, counting this edge.
  always_comb begin
    run_next = run_cnt;
    if (raw != cand) begin
      run_next = CW'(1);
    end else if (run_cnt != TARGET) begin
      run_next = run_cnt + 1'b1;
    end
  end

  // Track the candidate and adopt it once the run reaches DEBOUNCE samples.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= SENS_OK;
      run_cnt  <= '0;
      s_stable <= SENS_OK;
    end else begin
      cand    <= raw;
      run_cnt <= run_next;
      if (run_next == TARGET) begin
        s_stable <= raw;
      end
    end
  end

endmodule

// File: rtl/climate_controller.sv
// climate_controller: debounced two-sensor thermostat. A Moore FSM drives
// heater, cooler and alarm with a minimum on-time for heat/cool and a fault
// that stays latched until acknowledged with a healthy sensor code.
// Optional feature macro: CLIMATE_DEADTIME_EN -- when defined, every non-fault
// exit from HEAT/COOL passes through DEADT for DEAD cycles with both off.
module climate_controller
  import climate_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int MIN_ON   = 8,
  parameter int DEAD     = 4
) (
  input  logic       clk_2,
  input  logic       rst_n,
  input  logic [1:0] sensores,
  input  logic       fault_ack,
  output logic       heater,
  output logic       cooler,
  output logic       alarm,
  output logic [2:0] state_o
);

  // One counter serves as on_cnt in HEAT/COOL and as the dead-time counter in
  // DEADT; it is cleared on every state change, so the two uses never overlap.
  localparam int CNT_MAX = (MIN_ON > DEAD) ? MIN_ON : DEAD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(MIN_ON - 1);
`ifdef CLIMATE_DEADTIME_EN
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);
`endif

  logic [1:0]       s_stable;
  state_e           state;
  state_e           next_state;
  logic [CNT_W-1:0] hold_cnt;

  sensor_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk_2    (clk_2),
    .rst_n    (rst_n),
    .raw      (sensores),
    .s_stable (s_stable)
  );

  // Next-state logic: a stable fault code overrides everything else.
  always_comb begin
    next_state = state;
    if (s_stable == SENS_FAULT) begin
      next_state = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_stable == SENS_COLD)     next_state = ST_HEAT;
          else if (s_stable == SENS_HOT) next_state = ST_COOL;
        end
        ST_HEAT: begin
          if (hold_cnt == ON_LAST && s_stable != SENS_COLD) begin
`ifdef CLIMATE_DEADTIME_EN
            next_state = ST_DEADT;
`else
            next_state = (s_stable == SENS_HOT) ? ST_COOL : ST_IDLE;
`endif
          end
        end
        ST_COOL: begin
          if (hold_cnt == ON_LAST && s_stable != SENS_HOT) begin
`ifdef CLIMATE_DEADTIME_EN
            next_state = ST_DEADT;
`else
            next_state = (s_stable == SENS_COLD) ? ST_HEAT : ST_IDLE;
`endif
          end
        end
`ifdef CLIMATE_DEADTIME_EN
        ST_DEADT: begin
          if (hold_cnt == DEAD_LAST) next_state = ST_IDLE;
        end
`endif
        ST_FAULT: begin
          // s_stable is known healthy here, so the ack alone releases the latch.
          if (fault_ack) next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // State register and the shared saturating residency counter.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        hold_cnt <= '0;
      end else if ((state == ST_HEAT || state == ST_COOL) && hold_cnt != ON_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
`ifdef CLIMATE_DEADTIME_EN
      end else if (state == ST_DEADT && hold_cnt != DEAD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
`endif
      end
    end
  end

  // Moore outputs decoded from the state register only.
  assign heater  = (state == ST_HEAT);
  assign cooler  = (state == ST_COOL);
  assign alarm   = (state == ST_FAULT);
  assign state_o = state;

endmodule
